// File: rtl/game_sprite_sequencer.sv
// game_sprite_sequencer
// ---------------------
// Sequences one sprite's control/motion block through spawn, run, death and
// respawn. One instance sits between the game top-level FSM and one sprite.
//
// Life cycle: IDLE -(start)-> SPAWN (1 cycle) -> RUN -(hit or exit)-> DEAD
//             -(RESPAWN_FRAMES strobes)-> SPAWN on the next lane.
// stop returns to IDLE from any state.
//
// Every output is a register. A decision taken while in a state therefore
// shows up one cycle later: the SPAWN cycle produces the write pulses in the
// first RUN cycle, and the strobe that completes a motion step produces
// sprite_enable_update in the following cycle.
//
// Handshake: there is no valid/ready pair on this block. start, stop and
// frame_strobe are single-cycle pulses sampled on every clock edge.
// sprite_write_xy/dxy and sprite_enable_update are single-cycle pulses. The
// write data is valid only while its pulse is high and reads 0 otherwise.
//
// Ports
//   clk                  system clock
//   reset                synchronous reset, active low
//   start                pulse, leave IDLE (ignored in any other state)
//   stop                 pulse, return to IDLE (beats everything but reset)
//   frame_strobe         one-cycle pulse per video frame
//   sprite_within_screen sprite on-screen status from the sprite block
//   collision            level, the sprite hit something
//   sprite_write_xy      position load pulse
//   sprite_write_dxy     speed load pulse
//   sprite_write_x/y     spawn position (valid with sprite_write_xy)
//   sprite_write_dx/dy   spawn speed (valid with sprite_write_dxy)
//   sprite_enable_update one-cycle motion step pulse, RUN only
//   active               high while the sprite is live (SPAWN/RUN)
//   lane                 current spawn lane, 0..3
//   miss_count           off-screen exits, saturating at 255
//   hit_count            collisions, saturating at 255
//   dbg_state            current FSM state (0 IDLE, 1 SPAWN, 2 RUN, 3 DEAD)

`ifndef X_WIDTH
`define X_WIDTH 10
`endif
`ifndef Y_WIDTH
`define Y_WIDTH 9
`endif

module game_sprite_sequencer #(
    parameter int DX_WIDTH       = 2,
    parameter int DY_WIDTH       = 2,
    parameter int START_X        = 0,
    parameter int START_Y        = 0,
    parameter int LANE_STEP      = 64,
    parameter int START_DX       = 1,
    parameter int START_DY       = 0,
    parameter int UPDATE_DIV     = 1,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  frame_strobe,
    input  logic                  sprite_within_screen,
    input  logic                  collision,
    output logic                  sprite_write_xy,
    output logic                  sprite_write_dxy,
    output logic [`X_WIDTH-1:0]   sprite_write_x,
    output logic [`Y_WIDTH-1:0]   sprite_write_y,
    output logic [DX_WIDTH-1:0]   sprite_write_dx,
    output logic [DY_WIDTH-1:0]   sprite_write_dy,
    output logic                  sprite_enable_update,
    output logic                  active,
    output logic [1:0]            lane,
    output logic [7:0]            miss_count,
    output logic [7:0]            hit_count,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPAWN = 2'd1,
        ST_RUN   = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    // Parameter values cut to the width of the field they load.
    localparam logic [`X_WIDTH-1:0] START_X_W   = START_X[`X_WIDTH-1:0];
    localparam logic [`Y_WIDTH-1:0] START_Y_W   = START_Y[`Y_WIDTH-1:0];
    localparam logic [`Y_WIDTH-1:0] LANE_STEP_W = LANE_STEP[`Y_WIDTH-1:0];
    localparam logic [DX_WIDTH-1:0] START_DX_W  = START_DX[DX_WIDTH-1:0];
    localparam logic [DY_WIDTH-1:0] START_DY_W  = START_DY[DY_WIDTH-1:0];

    // Terminal values: the strobe seen while a counter holds its last value
    // is the one that completes the period.
    localparam logic [3:0] DIV_LAST  = 4'(UPDATE_DIV - 1);
    localparam logic [7:0] RESP_LAST = 8'(RESPAWN_FRAMES - 1);

    state_t               state_q;
    logic [3:0]           div_q;
    logic [7:0]           resp_q;
    logic                 seen_q;
    logic [1:0]           lane_q;
    logic [7:0]           miss_q;
    logic [7:0]           hit_q;
    logic                 active_q;
    logic                 wr_xy_q;
    logic                 wr_dxy_q;
    logic [`X_WIDTH-1:0]  wr_x_q;
    logic [`Y_WIDTH-1:0]  wr_y_q;
    logic [DX_WIDTH-1:0]  wr_dx_q;
    logic [DY_WIDTH-1:0]  wr_dy_q;
    logic                 upd_q;

    // Spawn row for the current lane; wraps naturally at the Y field width.
    logic [`Y_WIDTH-1:0]  spawn_y_d;
    logic                 exit_d;

    assign spawn_y_d = START_Y_W + LANE_STEP_W * {{(`Y_WIDTH-2){1'b0}}, lane_q};

    // The sprite only counts as having left the screen after it has been
    // seen on it at least once; a sprite that spawns off-screen and never
    // enters stays in RUN.
    assign exit_d = seen_q && !sprite_within_screen;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            resp_q   <= '0;
            seen_q   <= 1'b0;
            lane_q   <= '0;
            miss_q   <= '0;
            hit_q    <= '0;
            active_q <= 1'b0;
            wr_xy_q  <= 1'b0;
            wr_dxy_q <= 1'b0;
            wr_x_q   <= '0;
            wr_y_q   <= '0;
            wr_dx_q  <= '0;
            wr_dy_q  <= '0;
            upd_q    <= 1'b0;
        end else begin
            // Pulses and their data default low every cycle; only the
            // branches below raise them for a single cycle.
            wr_xy_q  <= 1'b0;
            wr_dxy_q <= 1'b0;
            wr_x_q   <= '0;
            wr_y_q   <= '0;
            wr_dx_q  <= '0;
            wr_dy_q  <= '0;
            upd_q    <= 1'b0;

            if (stop) begin
                // Counters, lane and divider are left untouched.
                state_q  <= ST_IDLE;
                active_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        active_q <= 1'b0;
                        if (start) begin
                            state_q <= ST_SPAWN;
                        end
                    end

                    ST_SPAWN: begin
                        wr_xy_q  <= 1'b1;
                        wr_dxy_q <= 1'b1;
                        wr_x_q   <= START_X_W;
                        wr_y_q   <= spawn_y_d;
                        wr_dx_q  <= START_DX_W;
                        wr_dy_q  <= START_DY_W;
                        div_q    <= '0;
                        seen_q   <= 1'b0;
                        // A stop during DEAD can leave a partial respawn
                        // count behind; start every life from zero.
                        resp_q   <= '0;
                        active_q <= 1'b1;
                        state_q  <= ST_RUN;
                    end

                    ST_RUN: begin
                        if (sprite_within_screen) begin
                            seen_q <= 1'b1;
                        end
                        if (collision) begin
                            // A hit wins over a simultaneous exit.
                            if (hit_q != 8'hFF) begin
                                hit_q <= hit_q + 8'd1;
                            end
                            active_q <= 1'b0;
                            state_q  <= ST_DEAD;
                        end else if (exit_d) begin
                            if (miss_q != 8'hFF) begin
                                miss_q <= miss_q + 8'd1;
                            end
                            active_q <= 1'b0;
                            state_q  <= ST_DEAD;
                        end else begin
                            // Motion steps only while staying in RUN, so a
                            // strobe on the dying cycle produces no pulse.
                            active_q <= 1'b1;
                            if (frame_strobe) begin
                                if (div_q == DIV_LAST) begin
                                    div_q <= '0;
                                    upd_q <= 1'b1;
                                end else begin
                                    div_q <= div_q + 4'd1;
                                end
                            end
                        end
                    end

                    ST_DEAD: begin
                        active_q <= 1'b0;
                        if (frame_strobe) begin
                            if (resp_q == RESP_LAST) begin
                                resp_q  <= '0;
                                lane_q  <= lane_q + 2'd1;
                                state_q <= ST_SPAWN;
                            end else begin
                                resp_q <= resp_q + 8'd1;
                            end
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign sprite_write_xy      = wr_xy_q;
    assign sprite_write_dxy     = wr_dxy_q;
    assign sprite_write_x       = wr_x_q;
    assign sprite_write_y       = wr_y_q;
    assign sprite_write_dx      = wr_dx_q;
    assign sprite_write_dy      = wr_dy_q;
    assign sprite_enable_update = upd_q;
    assign active               = active_q;
    assign lane                 = lane_q;
    assign miss_count           = miss_q;
    assign hit_count            = hit_q;
    assign dbg_state            = state_q;

endmodule
